// File: rtl/svi_pipe_bank.sv
// svi_pipe_bank: a bank of N_CH independent valid/data pipelines, each DEPTH
// stages deep. There is one global stall, a synchronous clear and an
// asynchronous reset. Each channel counts the items it delivers, and the
// counter wraps.
module svi_pipe_bank #(
  parameter int              WIDTH    = 8,
  parameter int              N_CH     = 3,
  parameter int              DEPTH    = 2,
  parameter int              CNT_W    = 8,
  parameter logic [WIDTH-1:0] ARST_VAL = '0,
  parameter logic [WIDTH-1:0] SRST_VAL = '1
) (
  input  logic                    i_clk,
  input  logic                    i_arst_n,
  input  logic                    i_srst,
  input  logic                    i_stall,
  input  logic [N_CH-1:0]         i_valid,
  input  logic [N_CH*WIDTH-1:0]   i_data,
  output logic                    o_ready,
  output logic [N_CH-1:0]         o_valid,
  output logic [N_CH*WIDTH-1:0]   o_data,
  output logic [N_CH*CNT_W-1:0]   o_count
);

  // Bit k of vld_q[c] is the valid flag of stage k. Stage DEPTH-1 is the output stage.
  logic [DEPTH-1:0] vld_q [N_CH];
  logic [DEPTH-1:0] vld_d [N_CH];
  logic [WIDTH-1:0] dat_q [N_CH][DEPTH];
  logic [WIDTH-1:0] dat_d [N_CH][DEPTH];
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];
  logic             adv;

  // Every stage moves only when no clear and no stall is present.
  // Input is accepted on exactly those same cycles.
  assign adv     = ~i_stall & ~i_srst;
  assign o_ready = adv;

  // Next state. A clear wins over a stall. On an advance, a data register
  // captures new data only behind a valid upstream stage, so bubbles never
  // overwrite data.
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      vld_d[c] = vld_q[c];
      cnt_d[c] = cnt_q[c];
      for (int k = 0; k < DEPTH; k++) begin
        dat_d[c][k] = dat_q[c][k];
      end
    end
    if (i_srst) begin
      for (int c = 0; c < N_CH; c++) begin
        vld_d[c] = '0;
        cnt_d[c] = '0;
        for (int k = 0; k < DEPTH; k++) begin
          dat_d[c][k] = SRST_VAL;
        end
      end
    end else if (adv) begin
      for (int c = 0; c < N_CH; c++) begin
        if (vld_q[c][DEPTH-1]) begin
          cnt_d[c] = cnt_q[c] + CNT_W'(1);
        end
        vld_d[c][0] = i_valid[c];
        if (i_valid[c]) begin
          dat_d[c][0] = i_data[c*WIDTH +: WIDTH];
        end
        for (int k = 1; k < DEPTH; k++) begin
          vld_d[c][k] = vld_q[c][k-1];
          if (vld_q[c][k-1]) begin
            dat_d[c][k] = dat_q[c][k-1];
          end
        end
      end
    end
  end

  // State registers. The asynchronous reset discards everything in flight.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      for (int c = 0; c < N_CH; c++) begin
        vld_q[c] <= '0;
        cnt_q[c] <= '0;
        for (int k = 0; k < DEPTH; k++) begin
          dat_q[c][k] <= ARST_VAL;
        end
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        vld_q[c] <= vld_d[c];
        cnt_q[c] <= cnt_d[c];
        for (int k = 0; k < DEPTH; k++) begin
          dat_q[c][k] <= dat_d[c][k];
        end
      end
    end
  end

  // Pack the last stage of each channel, and its counter, onto the output buses.
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      o_valid[c]                 = vld_q[c][DEPTH-1];
      o_data[c*WIDTH +: WIDTH]   = dat_q[c][DEPTH-1];
      o_count[c*CNT_W +: CNT_W]  = cnt_q[c];
    end
  end

endmodule

// File: tb/tb_svi_pipe_bank.sv
// Bench for svi_pipe_bank. Three configurations run in lockstep and share the
// clock, reset, clear and stall. Each channel is modelled as a queue of
// accepted items. Each item is stamped with the advance on which it was
// accepted. An item is on the output on exactly the advance (stamp + DEPTH - 1).
module tb_svi_pipe_bank;

  localparam int NCH [3] = '{3, 5, 1};
  localparam int DEP [3] = '{2, 4, 1};
  localparam int CW  [3] = '{8, 2, 4};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        arst_n, srst, stall;
  logic [4:0]  ivp [3];
  logic [39:0] idp [3];
  logic        rdy [3];

  logic [2:0]  ov0;  logic [23:0] od0;  logic [23:0] oc0;
  logic [4:0]  ov1;  logic [39:0] od1;  logic [9:0]  oc1;
  logic [0:0]  ov2;  logic [7:0]  od2;  logic [3:0]  oc2;

  svi_pipe_bank #(.WIDTH(8), .N_CH(3), .DEPTH(2), .CNT_W(8)) u0 (
    .i_clk(clk), .i_arst_n(arst_n), .i_srst(srst), .i_stall(stall),
    .i_valid(ivp[0][2:0]), .i_data(idp[0][23:0]),
    .o_ready(rdy[0]), .o_valid(ov0), .o_data(od0), .o_count(oc0));

  svi_pipe_bank #(.WIDTH(8), .N_CH(5), .DEPTH(4), .CNT_W(2)) u1 (
    .i_clk(clk), .i_arst_n(arst_n), .i_srst(srst), .i_stall(stall),
    .i_valid(ivp[1]), .i_data(idp[1]),
    .o_ready(rdy[1]), .o_valid(ov1), .o_data(od1), .o_count(oc1));

  svi_pipe_bank #(.WIDTH(8), .N_CH(1), .DEPTH(1), .CNT_W(4)) u2 (
    .i_clk(clk), .i_arst_n(arst_n), .i_srst(srst), .i_stall(stall),
    .i_valid(ivp[2][0:0]), .i_data(idp[2][7:0]),
    .o_ready(rdy[2]), .o_valid(ov2), .o_data(od2), .o_count(oc2));

  // Uniform views: one bit per channel, and an 8-bit slot per channel for data and counts.
  logic [4:0]  ovp [3];
  logic [39:0] odp [3];
  logic [39:0] ocp [3];
  assign ovp[0] = {2'b0, ov0};
  assign ovp[1] = ov1;
  assign ovp[2] = {4'b0, ov2};
  assign odp[0] = {16'b0, od0};
  assign odp[1] = od1;
  assign odp[2] = {32'b0, od2};
  assign ocp[0] = {16'b0, oc0};
  assign ocp[1] = {6'b0, oc1[9:8], 6'b0, oc1[7:6], 6'b0, oc1[5:4],
                   6'b0, oc1[3:2], 6'b0, oc1[1:0]};
  assign ocp[2] = {36'b0, oc2};

  // Reference model state.
  int          adv_n;
  int          mq_n [3][5][$];
  logic [7:0]  mq_d [3][5][$];
  logic        m_v  [3][5];
  logic [7:0]  m_d  [3][5];
  int          m_cnt[3][5];

  int total, bad;

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h @%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void m_clear(input logic [7:0] val);
    adv_n = 0;
    for (int i = 0; i < 3; i++)
      for (int c = 0; c < 5; c++) begin
        mq_n[i][c].delete();
        mq_d[i][c].delete();
        m_v[i][c]   = 1'b0;
        m_d[i][c]   = val;
        m_cnt[i][c] = 0;
      end
  endfunction

  // Applies the effect of the coming rising edge, using the inputs currently driven.
  function automatic void m_edge();
    if (!arst_n) return;
    if (srst) begin
      m_clear(8'hFF);
    end else if (!stall) begin
      for (int i = 0; i < 3; i++)
        for (int c = 0; c < NCH[i]; c++)
          if (m_v[i][c]) m_cnt[i][c]++;
      adv_n++;
      for (int i = 0; i < 3; i++)
        for (int c = 0; c < NCH[i]; c++) begin
          if (ivp[i][c]) begin
            mq_n[i][c].push_back(adv_n);
            mq_d[i][c].push_back(idp[i][c*8 +: 8]);
          end
          m_v[i][c] = 1'b0;
          while (mq_n[i][c].size() > 0 && mq_n[i][c][0] + DEP[i] - 1 <= adv_n) begin
            m_v[i][c] = (mq_n[i][c][0] + DEP[i] - 1 == adv_n);
            m_d[i][c] = mq_d[i][c][0];
            void'(mq_n[i][c].pop_front());
            void'(mq_d[i][c].pop_front());
          end
        end
    end
  endfunction

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d.ready", i), {39'b0, rdy[i]}, {39'b0, ~stall & ~srst});
      for (int c = 0; c < NCH[i]; c++) begin
        chk($sformatf("u%0d.c%0d.valid", i, c), {39'b0, ovp[i][c]}, {39'b0, m_v[i][c]});
        chk($sformatf("u%0d.c%0d.data", i, c), {32'b0, odp[i][c*8 +: 8]}, {32'b0, m_d[i][c]});
        chk($sformatf("u%0d.c%0d.count", i, c), {32'b0, ocp[i][c*8 +: 8]},
            40'(m_cnt[i][c] % (1 << CW[i])));
      end
    end
  endtask

  task automatic step();
    m_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 3; i++) ivp[i] = '0;
  endtask

  // Asserts the reset between clock edges and checks the outputs before any edge arrives.
  task automatic arst_async();
    #3;
    arst_n = 1'b0;
    m_clear(8'h00);
    #1;
    check_all();
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < 3; i++) begin
      ivp[i]        = 5'($urandom());
      idp[i][31:0]  = $urandom();
      idp[i][39:32] = 8'($urandom());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    total = 0; bad = 0;
    arst_n = 1'b0; srst = 1'b0; stall = 1'b0;
    for (int i = 0; i < 3; i++) begin ivp[i] = '0; idp[i] = '0; end
    m_clear(8'h00);
    #2;
    check_all();

    // Held in reset: valid input and an edge change nothing.
    for (int i = 0; i < 3; i++) ivp[i] = 5'h1F;
    step();
    idle_inputs();
    #2 arst_n = 1'b1;

    // Single item on ch0 with DEPTH 2.
    ivp[0] = 5'b00001; idp[0][7:0] = 8'hA5;
    step();
    idle_inputs();
    step();
    chk("single.valid", {39'b0, ov0[0]}, 40'd1);
    chk("single.data", {32'b0, od0[7:0]}, 40'hA5);
    step();
    chk("single.valid_off", {39'b0, ov0[0]}, 40'd0);
    chk("single.count", {32'b0, oc0[7:0]}, 40'd1);

    // Three items on ch1. A stall drops the middle one.
    ivp[0] = 5'b00010; idp[0][15:8] = 8'h01;
    step();
    idp[0][15:8] = 8'h02; stall = 1'b1;
    step();
    idp[0][15:8] = 8'h03; stall = 1'b0;
    step();
    idle_inputs();
    step(); step(); step();
    chk("stall.count", {32'b0, oc0[15:8]}, 40'd2);
    chk("stall.data", {32'b0, od0[15:8]}, 40'h03);

    // Fill the stages, then clear while stalled.
    for (int n = 0; n < 4; n++) begin rand_inputs(); for (int i = 0; i < 3; i++) ivp[i] = 5'h1F; step(); end
    stall = 1'b1; srst = 1'b1;
    step();
    chk("srst.valid0", {37'b0, ov0}, 40'd0);
    chk("srst.data0", {16'b0, od0}, 40'hFFFFFF);
    chk("srst.count0", {16'b0, oc0}, 40'd0);
    chk("srst.valid1", {35'b0, ov1}, 40'd0);
    chk("srst.data1", od1, 40'hFF_FFFF_FFFF);
    srst = 1'b0; stall = 1'b0; idle_inputs();

    // Five deliveries on u1 ch2 with a 2-bit counter wrap to 1.
    for (int n = 0; n < 5; n++) begin ivp[1] = 5'b00100; idp[1][23:16] = 8'(n + 8'h30); step(); end
    idle_inputs();
    for (int n = 0; n < 5; n++) step();
    chk("wrap.c2", {38'b0, oc1[5:4]}, 40'd1);
    chk("wrap.c0", {38'b0, oc1[1:0]}, 40'd0);
    chk("wrap.c1", {38'b0, oc1[3:2]}, 40'd0);

    // Reset between edges while every stage is full.
    for (int n = 0; n < 5; n++) begin rand_inputs(); for (int i = 0; i < 3; i++) ivp[i] = 5'h1F; step(); end
    arst_async();
    chk("arst.valid0", {37'b0, ov0}, 40'd0);
    chk("arst.data0", {16'b0, od0}, 40'd0);
    chk("arst.valid1", {35'b0, ov1}, 40'd0);
    chk("arst.data1", od1, 40'd0);
    chk("arst.count0", {16'b0, oc0}, 40'd0);
    step();
    #2 arst_n = 1'b1;
    idle_inputs();

    // Random traffic with stalls, clears and occasional asynchronous resets.
    for (int n = 0; n < 1500; n++) begin
      rand_inputs();
      stall = ($urandom() % 5) == 0;
      srst  = ($urandom() % 40) == 0;
      step();
      if (($urandom() % 150) == 0) begin
        arst_async();
        step();
        #2 arst_n = 1'b1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
